// File: rtl/vd_pkg.sv
// Shared encoder/decoder constants: code parameters, frame widths and encoder FSM states.
// Pure definitions; no logic, latency or flow control of its own.
package vd_pkg;

    localparam int K            = 3;
    localparam int FRAME_DATA_W = 8;
    localparam int FRAME_CODE_W = 2 * FRAME_DATA_W;

    // Octal 7 and octal 5, the classic K=3 rate-1/2 pair
    localparam logic [K-1:0] ENC_G0 = 3'b111;
    localparam logic [K-1:0] ENC_G1 = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        DONE = 2'd2
    } enc_state_t;

endpackage

// File: rtl/conv_enc_step.sv
// One trellis step: coded pair (c0, c1) and next shift-register value for input bit b.
// Purely combinational, no flow control; also used by the decoder branch-metric model.
module conv_enc_step
    import vd_pkg::*;
#(
    parameter logic [K-1:0] G0 = ENC_G0,
    parameter logic [K-1:0] G1 = ENC_G1
) (
    input  logic         b,
    input  logic [K-2:0] sr,
    output logic         c0,
    output logic         c1,
    output logic [K-2:0] sr_nxt
);

    logic [K-1:0] taps;

    assign taps   = {b, sr};
    assign c0     = ^(taps & G0);
    assign c1     = ^(taps & G1);
    assign sr_nxt = {b, sr[K-2:1]};

endmodule

// File: rtl/conv_encoder_frame.sv
// Serial rate-1/2 K=3 encoder building one 2*DATA_W-bit frame per accepted byte; o_valid 8 edges after accept.
// Backpressure: o_ready only in IDLE, bytes offered while busy are dropped, not queued.
module conv_encoder_frame
    import vd_pkg::*;
#(
    parameter int           DATA_W          = FRAME_DATA_W,
    parameter logic [K-1:0] G0              = ENC_G0,
    parameter logic [K-1:0] G1              = ENC_G1,
    parameter bit           CLEAR_PER_FRAME = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    input  logic [DATA_W-1:0]   i_data,
    output logic                o_ready,
    output logic [2*DATA_W-1:0] o_data,
    output logic                o_valid,
    output logic                o_busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    enc_state_t          state;
    enc_state_t          state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   shbuf;
    logic [K-2:0]        sr;
    logic [K-2:0]        sr_nxt;
    logic [2*DATA_W-1:0] stage;
    logic [2*DATA_W-1:0] stage_nxt;
    logic [2*DATA_W-1:0] data_q;
    logic                c0;
    logic                c1;
    logic                last_bit;

    conv_enc_step #(
        .G0 (G0),
        .G1 (G1)
    ) u_step (
        .b      (shbuf[DATA_W-1]),
        .sr     (sr),
        .c0     (c0),
        .c1     (c1),
        .sr_nxt (sr_nxt)
    );

    assign last_bit = (cnt == CNT_W'(DATA_W - 1));

    // Bit k's pair lands at the top end first so the frame reads MSB-first.
    always_comb begin
        stage_nxt = stage;
        for (int k = 0; k < DATA_W; k++) begin
            if (cnt == CNT_W'(k)) begin
                stage_nxt[2*(DATA_W-1-k) +: 2] = {c0, c1};
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_valid) state_nxt = ENC;
            ENC:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt    <= '0;
            shbuf  <= '0;
            sr     <= '0;
            stage  <= '0;
            data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        shbuf <= i_data;
                        cnt   <= '0;
                        stage <= '0;
                        if (CLEAR_PER_FRAME) begin
                            sr <= '0;
                        end
                    end
                end
                ENC: begin
                    shbuf <= {shbuf[DATA_W-2:0], 1'b0};
                    sr    <= sr_nxt;
                    stage <= stage_nxt;
                    if (last_bit) begin
                        data_q <= stage_nxt;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);
    assign o_busy  = (state == ENC) || (state == DONE);
    assign o_data  = data_q;

endmodule

// File: tb/tb_conv_encoder_frame.sv
// Bench for conv_encoder_frame: one clearing and one carrying instance share stimulus
// and are compared edge by edge against a bit-serial arithmetic model of the code.
module tb_conv_encoder_frame;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;

    logic        clr_ready, clr_valid, clr_busy;
    logic [15:0] clr_data;
    logic        car_ready, car_valid, car_busy;
    logic [15:0] car_data;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] last_clr = 16'h0;
    logic [15:0] last_car = 16'h0;
    logic [1:0]  carry_sr = 2'b00;

    always #5 clk = ~clk;

    conv_encoder_frame #(.CLEAR_PER_FRAME(1'b1)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (in_valid),
        .i_data  (in_data),
        .o_ready (clr_ready),
        .o_data  (clr_data),
        .o_valid (clr_valid),
        .o_busy  (clr_busy)
    );

    conv_encoder_frame #(.CLEAR_PER_FRAME(1'b0)) dut_carry (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (in_valid),
        .i_data  (in_data),
        .o_ready (car_ready),
        .o_data  (car_data),
        .o_valid (car_valid),
        .o_busy  (car_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // hist[1] = previous input bit, hist[0] = the one before it
    function automatic logic [15:0] enc_model(input logic [7:0] d, input logic [1:0] hist,
                                              output logic [1:0] hist_out);
        int p1, p2, b;
        logic [15:0] r;
        r  = 16'h0;
        p1 = int'(hist[1]);
        p2 = int'(hist[0]);
        for (int k = 0; k < 8; k++) begin
            b = int'(d[7-k]);
            r = (r << 2) | 16'(((b + p1 + p2) % 2) * 2 + ((b + p2) % 2));
            p2 = p1;
            p1 = b;
        end
        hist_out = {1'(p1), 1'(p2)};
        return r;
    endfunction

    function automatic logic [31:0] pack(input logic rdy, input logic vld, input logic bsy,
                                         input logic [15:0] d);
        return {13'd0, rdy, vld, bsy, d};
    endfunction

    task automatic check_both(input string tag, input logic rdy, input logic vld, input logic bsy);
        check({"clr_", tag}, pack(clr_ready, clr_valid, clr_busy, clr_data), pack(rdy, vld, bsy, last_clr));
        check({"car_", tag}, pack(car_ready, car_valid, car_busy, car_data), pack(rdy, vld, bsy, last_car));
    endtask

    task automatic run_frame(input logic [7:0] d);
        logic [15:0] e_clr, e_car;
        logic [1:0]  h, unused_h;
        e_clr = enc_model(d, 2'b00, unused_h);
        e_car = enc_model(d, carry_sr, h);
        @(negedge clk);
        check_both("pre_accept", 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        for (int e = 0; e <= 9; e++) begin
            if (e > 0) begin
                @(posedge clk);
                #1;
            end
            if (e == 8) begin
                last_clr = e_clr;
                last_car = e_car;
                carry_sr = h;
            end
            check_both($sformatf("frame_%02h_e%0d", d, e), e == 9, e == 8, e < 9);
        end
    endtask

    initial begin
        logic [7:0]  arr [0:40];
        logic [15:0] e_clr;
        logic [1:0]  h, unused_h;

        #12;
        check_both("reset", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(8'h01);
        check("vec_01_clr", 32'(clr_data), 32'h0003);
        check("vec_01_car", 32'(car_data), 32'h0003);
        run_frame(8'h00);
        check("vec_00_clr", 32'(clr_data), 32'h0000);
        check("vec_00_car", 32'(car_data), 32'hB000);
        run_frame(8'h80);
        check("vec_80_clr", 32'(clr_data), 32'hEC00);
        run_frame(8'hFF);
        check("vec_FF_clr", 32'(clr_data), 32'hDAAA);

        // i_valid held high with data changing every cycle
        @(negedge clk);
        in_valid = 1'b1;
        arr[0]   = 8'($urandom);
        in_data  = arr[0];
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (i % 10 == 8) begin
                last_clr = enc_model(arr[i-8], 2'b00, unused_h);
                last_car = enc_model(arr[i-8], carry_sr, h);
                carry_sr = h;
            end
            check_both($sformatf("stream_%0d", i), i % 10 == 9, i % 10 == 8, i % 10 != 9);
            @(negedge clk);
            if (i < 39) begin
                arr[i+1] = 8'($urandom);
                in_data  = arr[i+1];
            end else begin
                in_valid = 1'b0;
            end
        end

        // Reset in the middle of ENC aborts the frame
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        last_clr = 16'h0;
        last_car = 16'h0;
        carry_sr = 2'b00;
        check_both("mid_reset", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check_both($sformatf("post_reset_%0d", i), 1'b1, 1'b0, 1'b0);
        end
        run_frame(8'h80);
        check("vec_80_after_rst_clr", 32'(clr_data), 32'hEC00);
        check("vec_80_after_rst_car", 32'(car_data), 32'hEC00);

        for (int n = 0; n < 200; n++) begin
            run_frame(8'($urandom));
        end

        e_clr = enc_model(8'h5A, 2'b00, unused_h);
        run_frame(8'h5A);
        check("vec_5A_clr", 32'(clr_data), 32'(e_clr));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
